// File: rtl/operand_unpacker.sv
// Fetches a run of 64-bit words from synchronous memory and streams each one
// to the ALU as two DATA_W operands, low half first.
module operand_unpacker #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W-1:0]        num_words_i,
  output logic                     read_en_o,
  output logic [ADDR_W-1:0]        read_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_data_i,
  output logic [DATA_W-1:0]        op_o,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic                     op_hi_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND_LO, S_SEND_HI, S_DONE
  } state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_base, r_cnt, r_idx;
  logic [MEM_WORD_SIZE-1:0] r_hold;
  logic                     r_read_en, r_op_valid, r_op_hi, r_busy, r_done;
  logic [ADDR_W-1:0]        r_read_addr;
  logic [DATA_W-1:0]        r_op;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_hold      <= '0;
      r_read_en   <= 1'b0;
      r_read_addr <= '0;
      r_op        <= '0;
      r_op_valid  <= 1'b0;
      r_op_hi     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Strobes last exactly one state; re-asserted only on entry to READ/DONE.
      r_read_en   <= 1'b0;
      r_read_addr <= '0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base <= base_addr_i;
            r_cnt  <= num_words_i;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (num_words_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_READ;
              r_read_en   <= 1'b1;
              r_read_addr <= base_addr_i;
            end
          end
        end
        S_READ: r_state <= S_LATCH;
        S_LATCH: begin
          r_hold     <= mem_data_i;
          r_op       <= mem_data_i[DATA_W-1:0];
          r_op_valid <= 1'b1;
          r_op_hi    <= 1'b0;
          r_state    <= S_SEND_LO;
        end
        S_SEND_LO: begin
          if (op_ready_i) begin
            r_op    <= r_hold[MEM_WORD_SIZE-1:DATA_W];
            r_op_hi <= 1'b1;
            r_state <= S_SEND_HI;
          end else begin
            r_op    <= r_hold[DATA_W-1:0];
          end
        end
        S_SEND_HI: begin
          if (op_ready_i) begin
            r_op       <= '0;
            r_op_valid <= 1'b0;
            r_op_hi    <= 1'b0;
            if (r_idx == r_cnt - ADDR_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx       <= r_idx + ADDR_W'(1);
              r_state     <= S_READ;
              r_read_en   <= 1'b1;
              r_read_addr <= r_base + r_idx + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_en_o   = r_read_en;
  assign read_addr_o = r_read_addr;
  assign op_o        = r_op;
  assign op_valid_o  = r_op_valid;
  assign op_hi_o     = r_op_hi;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule
